// File: rtl/uart_pkg.sv
// Shared definitions for the UART image loader.
//   rx_state_t   : receiver FSM state encoding
//   DATABITS     : data bits per UART frame
//   BYTESPERWORD : bytes packed into one RAM word
package uart_pkg;

  localparam int DATABITS     = 8;
  localparam int BYTESPERWORD = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } rx_state_t;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver running on an oversampled clock.
// Ports:
//   clk       in   oversampled bit clock (OVERSAMPLE x baud)
//   nrst      in   asynchronous active-low reset
//   datai     in   serial line, idle high, LSB first
//   hold      in   when high, start bits are ignored in IDLE
//   bytevalid out  one-cycle pulse, rxbyte holds a good byte
//   rxbyte    out  last received byte
//   frameerr  out  one-cycle pulse, stop bit sampled low
//
// state | meaning
// ------+--------------------------------------------------------
// IDLE  | line idle, waiting for a falling edge on rxs
// START | counting to the middle of the start bit to confirm it
// DATA  | sampling eight data bits, one per OVERSAMPLE cycles
// STOP  | sampling the stop bit
// BREAK | stop bit was low; wait for the line to return high
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = 16
) (
  input  logic                clk,
  input  logic                nrst,
  input  logic                datai,
  input  logic                hold,
  output logic                bytevalid,
  output logic [DATABITS-1:0] rxbyte,
  output logic                frameerr
);

  localparam int SCW = $clog2(OVERSAMPLE);
  localparam int BIW = $clog2(DATABITS);
  localparam logic [SCW-1:0] SC_HALF = SCW'(OVERSAMPLE / 2 - 1);
  localparam logic [SCW-1:0] SC_LAST = SCW'(OVERSAMPLE - 1);
  localparam logic [BIW-1:0] BI_LAST = BIW'(DATABITS - 1);

  logic                sync1, rxs;
  rx_state_t           state, state_n;
  logic [SCW-1:0]      sc, sc_n;
  logic [BIW-1:0]      bitidx, bitidx_n;
  logic [DATABITS-1:0] shreg, shreg_n;

  // Two-flop synchroniser; resets to the idle line level so reset
  // release never looks like a start bit.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
    end else begin
      sync1 <= datai;
      rxs   <= sync1;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state  <= IDLE;
      sc     <= '0;
      bitidx <= '0;
      shreg  <= '0;
    end else begin
      state  <= state_n;
      sc     <= sc_n;
      bitidx <= bitidx_n;
      shreg  <= shreg_n;
    end
  end

  always_comb begin
    state_n   = state;
    sc_n      = sc;
    bitidx_n  = bitidx;
    shreg_n   = shreg;
    bytevalid = 1'b0;
    frameerr  = 1'b0;
    case (state)
      IDLE: begin
        sc_n = '0;
        if (!hold && !rxs) state_n = START;
      end
      START: begin
        if (sc == SC_HALF) begin
          sc_n     = '0;
          bitidx_n = '0;
          // A line that is high again at mid start bit was a glitch.
          state_n  = rxs ? IDLE : DATA;
        end else begin
          sc_n = sc + 1'b1;
        end
      end
      DATA: begin
        if (sc == SC_LAST) begin
          sc_n    = '0;
          shreg_n = {rxs, shreg[DATABITS-1:1]};
          if (bitidx == BI_LAST) state_n  = STOP;
          else                   bitidx_n = bitidx + 1'b1;
        end else begin
          sc_n = sc + 1'b1;
        end
      end
      STOP: begin
        if (sc == SC_LAST) begin
          sc_n = '0;
          if (rxs) begin
            bytevalid = 1'b1;
            state_n   = IDLE;
          end else begin
            frameerr  = 1'b1;
            state_n   = BREAK;
          end
        end else begin
          sc_n = sc + 1'b1;
        end
      end
      BREAK: begin
        sc_n = '0;
        if (rxs) state_n = IDLE;
      end
      default: begin
        sc_n    = '0;
        state_n = IDLE;
      end
    endcase
  end

  assign rxbyte = shreg;

endmodule

// File: rtl/uart_rx_loader.sv
// UART image loader: receives bytes, packs four little-endian bytes
// per word and writes them to the RAM second port from BASEADDR up.
// Ports:
//   clk        in   oversampled bit clock (OVERSAMPLE x baud)
//   nrst       in   asynchronous active-low reset
//   datai      in   UART serial in, idle high, LSB first
//   wram       out  RAM write enable, one-cycle pulse
//   ramaddress out  RAM word address
//   wramdata   out  packed word
//   done       out  sticky, DEPTH words written
//   frameerr   out  one-cycle pulse, stop bit sampled low
module uart_rx_loader
  import uart_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int OVERSAMPLE = 16,
  parameter int BASEADDR   = 0,
  parameter int DEPTH      = 411699
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             datai,
  output logic             wram,
  output logic [WIDTH-1:0] ramaddress,
  output logic [WIDTH-1:0] wramdata,
  output logic             done,
  output logic             frameerr
);

  localparam int LANEW = $clog2(BYTESPERWORD);
  localparam logic [LANEW-1:0] LANE_LAST  = LANEW'(BYTESPERWORD - 1);
  localparam logic [WIDTH-1:0] FIRST_ADDR = WIDTH'(BASEADDR);
  localparam logic [WIDTH-1:0] LAST_ADDR  = WIDTH'(BASEADDR + DEPTH - 1);

  logic                                  bytevalid;
  logic [DATABITS-1:0]                   rxbyte;
  logic [LANEW-1:0]                      lane;
  logic [DATABITS*(BYTESPERWORD-1)-1:0]  word;
  logic [DATABITS*BYTESPERWORD-1:0]      fullword;

  uart_rx_byte #(
    .OVERSAMPLE (OVERSAMPLE)
  ) u_rx (
    .clk       (clk),
    .nrst      (nrst),
    .datai     (datai),
    .hold      (done),
    .bytevalid (bytevalid),
    .rxbyte    (rxbyte),
    .frameerr  (frameerr)
  );

  // Only the lower three lanes are stored; the top lane goes straight
  // from the receiver into the written word.
  assign fullword = {rxbyte, word};

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      lane     <= '0;
      word     <= '0;
      wram     <= 1'b0;
      wramdata <= '0;
    end else begin
      wram <= 1'b0;
      // Bytes still in flight when done rises are dropped here.
      if (bytevalid && !done) begin
        if (lane == LANE_LAST) begin
          wram     <= 1'b1;
          wramdata <= WIDTH'(fullword);
          lane     <= '0;
        end else begin
          case (lane)
            2'd0:    word[7:0]   <= rxbyte;
            2'd1:    word[15:8]  <= rxbyte;
            default: word[23:16] <= rxbyte;
          endcase
          lane <= lane + 1'b1;
        end
      end
    end
  end

  // The address advances the cycle after each write; the final write
  // sets done instead, so the address parks on the last word.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      ramaddress <= FIRST_ADDR;
      done       <= 1'b0;
    end else if (wram) begin
      if (ramaddress == LAST_ADDR) done       <= 1'b1;
      else                         ramaddress <= ramaddress + 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_rx_loader.sv
// Self-checking bench for uart_rx_loader: table of bytes with expected
// write results for a default instance, plus hand sequences for glitch,
// mid-frame reset and the DEPTH/BASEADDR boundary on a second instance.
module tb_uart_rx_loader;

  localparam int OS = 16;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        datai1 = 1'b1;
  logic        datai2 = 1'b1;

  logic        wram1, done1, ferr1;
  logic [31:0] addr1, data1;
  logic        wram2, done2, ferr2;
  logic [31:0] addr2, data2;

  always #5 clk = ~clk;

  uart_rx_loader #(.WIDTH(32), .OVERSAMPLE(OS), .BASEADDR(0), .DEPTH(411699)) dut1 (
    .clk(clk), .nrst(nrst), .datai(datai1), .wram(wram1),
    .ramaddress(addr1), .wramdata(data1), .done(done1), .frameerr(ferr1)
  );

  uart_rx_loader #(.WIDTH(32), .OVERSAMPLE(OS), .BASEADDR(8), .DEPTH(2)) dut2 (
    .clk(clk), .nrst(nrst), .datai(datai2), .wram(wram2),
    .ramaddress(addr2), .wramdata(data2), .done(done2), .frameerr(ferr2)
  );

  int tests = 0;
  int fails = 0;

  int          wcnt1 = 0, fcnt1 = 0, wcnt2 = 0, fcnt2 = 0;
  logic [31:0] last_a1, last_d1;
  logic [31:0] wa2[$];
  logic [31:0] wd2[$];

  always @(negedge clk) begin
    if (wram1) begin
      wcnt1++;
      last_a1 = addr1;
      last_d1 = data1;
    end
    if (ferr1) fcnt1++;
    if (wram2) begin
      wcnt2++;
      wa2.push_back(addr2);
      wd2.push_back(data2);
    end
    if (ferr2) fcnt2++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    nrst = 1'b0;
    repeat (3) @(negedge clk);
    nrst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic drive(input int line, input logic v);
    if (line == 1) datai1 = v;
    else           datai2 = v;
  endtask

  // One 8N1 frame followed by a short idle gap.
  task automatic send(input int line, input logic [7:0] b, input logic stop_ok);
    drive(line, 1'b0);
    repeat (OS) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      drive(line, b[i]);
      repeat (OS) @(negedge clk);
    end
    drive(line, stop_ok);
    repeat (OS) @(negedge clk);
    drive(line, 1'b1);
    repeat (OS / 2) @(negedge clk);
  endtask

  typedef struct {
    bit          rst;
    bit          glitch;
    logic [7:0]  b;
    bit          stop_ok;
    int          exp_wr;
    int          exp_ferr;
    logic [31:0] exp_addr;
    logic [31:0] exp_data;
    logic [31:0] exp_ra;
  } vec_t;

  vec_t vecs[17];

  initial begin
    int w0, f0;

    vecs[0]  = '{1, 0, 8'h55, 1, 0, 0, 32'd0, 32'h0,        32'd0};
    vecs[1]  = '{0, 0, 8'h66, 1, 0, 0, 32'd0, 32'h0,        32'd0};
    vecs[2]  = '{0, 0, 8'h77, 1, 0, 0, 32'd0, 32'h0,        32'd0};
    vecs[3]  = '{0, 0, 8'h88, 1, 1, 0, 32'd0, 32'h88776655, 32'd1};
    vecs[4]  = '{0, 0, 8'h11, 1, 0, 0, 32'd0, 32'h0,        32'd1};
    vecs[5]  = '{0, 0, 8'h22, 1, 0, 0, 32'd0, 32'h0,        32'd1};
    vecs[6]  = '{0, 0, 8'h33, 1, 0, 0, 32'd0, 32'h0,        32'd1};
    vecs[7]  = '{0, 0, 8'h44, 1, 1, 0, 32'd1, 32'h44332211, 32'd2};
    vecs[8]  = '{0, 1, 8'hC3, 1, 0, 0, 32'd0, 32'h0,        32'd2};
    vecs[9]  = '{0, 0, 8'h5A, 1, 0, 0, 32'd0, 32'h0,        32'd2};
    vecs[10] = '{0, 0, 8'h96, 1, 0, 0, 32'd0, 32'h0,        32'd2};
    vecs[11] = '{0, 0, 8'h0F, 1, 1, 0, 32'd2, 32'h0F965AC3, 32'd3};
    vecs[12] = '{1, 0, 8'hA5, 0, 0, 1, 32'd0, 32'h0,        32'd0};
    vecs[13] = '{0, 0, 8'h01, 1, 0, 0, 32'd0, 32'h0,        32'd0};
    vecs[14] = '{0, 0, 8'h02, 1, 0, 0, 32'd0, 32'h0,        32'd0};
    vecs[15] = '{0, 0, 8'h03, 1, 0, 0, 32'd0, 32'h0,        32'd0};
    vecs[16] = '{0, 0, 8'h04, 1, 1, 0, 32'd0, 32'h04030201, 32'd1};

    // Reset values, sampled while reset is asserted.
    repeat (3) @(negedge clk);
    check("rst_wram",     {31'd0, wram1}, 32'd0);
    check("rst_addr",     addr1,          32'd0);
    check("rst_data",     data1,          32'd0);
    check("rst_done",     {31'd0, done1}, 32'd0);
    check("rst_ferr",     {31'd0, ferr1}, 32'd0);
    check("rst_addr_b8",  addr2,          32'd8);
    nrst = 1'b1;
    repeat (4) @(negedge clk);

    for (int i = 0; i < 17; i++) begin
      if (vecs[i].rst) do_reset();
      if (vecs[i].glitch) begin
        datai1 = 1'b0;
        repeat (3) @(negedge clk);
        datai1 = 1'b1;
        repeat (2 * OS) @(negedge clk);
      end
      w0 = wcnt1;
      f0 = fcnt1;
      send(1, vecs[i].b, vecs[i].stop_ok);
      check($sformatf("v%0d_wr_count", i), 32'(wcnt1 - w0), 32'(vecs[i].exp_wr));
      check($sformatf("v%0d_ferr_count", i), 32'(fcnt1 - f0), 32'(vecs[i].exp_ferr));
      if (vecs[i].exp_wr == 1) begin
        check($sformatf("v%0d_wr_addr", i), last_a1, vecs[i].exp_addr);
        check($sformatf("v%0d_wr_data", i), last_d1, vecs[i].exp_data);
      end
      check($sformatf("v%0d_ramaddress", i), addr1, vecs[i].exp_ra);
      check($sformatf("v%0d_done", i), {31'd0, done1}, 32'd0);
    end

    // Reset during the data bits of the third byte of a word.
    send(1, 8'h10, 1'b1);
    send(1, 8'h20, 1'b1);
    w0 = wcnt1;
    datai1 = 1'b0;
    repeat (OS) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      datai1 = i[0];
      repeat (OS) @(negedge clk);
    end
    nrst = 1'b0;
    repeat (2) @(negedge clk);
    check("midrst_wram", {31'd0, wram1}, 32'd0);
    check("midrst_addr", addr1,          32'd0);
    check("midrst_data", data1,          32'd0);
    check("midrst_done", {31'd0, done1}, 32'd0);
    check("midrst_ferr", {31'd0, ferr1}, 32'd0);
    datai1 = 1'b1;
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    repeat (4) @(negedge clk);
    send(1, 8'hDE, 1'b1);
    send(1, 8'hAD, 1'b1);
    send(1, 8'hBE, 1'b1);
    send(1, 8'hEF, 1'b1);
    check("midrst_wr_count", 32'(wcnt1 - w0), 32'd1);
    check("midrst_wr_addr",  last_a1,         32'd0);
    check("midrst_wr_data",  last_d1,         32'hEFBEADDE);
    check("midrst_ra_after", addr1,           32'd1);

    // DEPTH=2 at BASEADDR=8: twelve bytes, only two writes.
    do_reset();
    for (int i = 0; i < 4; i++) send(2, 8'(8'h10 + i), 1'b1);
    check("d2_done_after1", {31'd0, done2}, 32'd0);
    check("d2_ra_after1",   addr2,          32'd9);
    for (int i = 4; i < 8; i++) send(2, 8'(8'h10 + i), 1'b1);
    check("d2_done_after2", {31'd0, done2}, 32'd1);
    for (int i = 8; i < 12; i++) send(2, 8'(8'h10 + i), 1'b1);
    check("d2_wr_count",    32'(wcnt2),     32'd2);
    check("d2_ferr_count",  32'(fcnt2),     32'd0);
    check("d2_ra_final",    addr2,          32'd9);
    check("d2_done_final",  {31'd0, done2}, 32'd1);
    if (wa2.size() >= 2) begin
      check("d2_addr0", wa2[0], 32'd8);
      check("d2_data0", wd2[0], 32'h13121110);
      check("d2_addr1", wa2[1], 32'd9);
      check("d2_data1", wd2[1], 32'h17161514);
    end else begin
      tests++;
      fails++;
      $display("FAIL d2_writes: got %0d writes expected 2", wa2.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
